// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, control-bit positions and the control word type.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMWRITE  = 1;
    localparam int CTRL_MEMREAD   = 2;
    localparam int CTRL_SRCB_LSB  = 3;
    localparam int CTRL_ALUOP_LSB = 5;
    localparam int CTRL_REGDST    = 7;

    typedef struct packed {
        logic       reg_dst;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Unknown opcodes decode to the all-zero NOP control word.
    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        logic [7:0] c;
        c = CTRL_NOP;
        case (op)
            OP_RTYPE: begin
                c[CTRL_REGDST]          = 1'b1;
                c[CTRL_ALUOP_LSB +: 2]  = 2'b10;
                c[CTRL_REGWRITE]        = 1'b1;
            end
            OP_LW: begin
                c[CTRL_SRCB_LSB +: 2]   = 2'b01;
                c[CTRL_MEMREAD]         = 1'b1;
                c[CTRL_REGWRITE]        = 1'b1;
            end
            OP_SW: begin
                c[CTRL_SRCB_LSB +: 2]   = 2'b01;
                c[CTRL_MEMWRITE]        = 1'b1;
            end
            OP_ADDI: begin
                c[CTRL_SRCB_LSB +: 2]   = 2'b01;
                c[CTRL_REGWRITE]        = 1'b1;
            end
            OP_ORI: begin
                c[CTRL_ALUOP_LSB +: 2]  = 2'b11;
                c[CTRL_SRCB_LSB +: 2]   = 2'b10;
                c[CTRL_REGWRITE]        = 1'b1;
            end
            default: c = CTRL_NOP;
        endcase
        return ctrl_t'(c);
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Two-read, one-write register file; r0 and indices >= NREG read zero.
// WB_BYPASS_EN: a same-cycle writeback to the read index is forwarded to the read port.
module id_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic [4:0]      ra0_i,
    input  logic [4:0]      ra1_i,
    output logic [XLEN-1:0] rd0_o,
    output logic [XLEN-1:0] rd1_o
);

    logic [XLEN-1:0] regs [32];

    for (genvar gi = 0; gi < 32; gi++) begin : g_reg
        if (gi == 0 || gi >= NREG) begin : g_zero
            assign regs[gi] = '0;
        end else begin : g_flop
            logic [XLEN-1:0] r_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (we_i && wa_i == 5'(gi)) begin
                    r_q <= wd_i;
                end
            end
            assign regs[gi] = r_q;
        end
    end

`ifdef WB_BYPASS_EN
    assign rd0_o = (we_i && wa_i != 5'd0 && wa_i == ra0_i) ? wd_i : regs[ra0_i];
    assign rd1_o = (we_i && wa_i != 5'd0 && wa_i == ra1_i) ? wd_i : regs[ra1_i];
`else
    assign rd0_o = regs[ra0_i];
    assign rd1_o = regs[ra1_i];
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with load-use hazard detection and its own ID/EX register.
// Build option WB_BYPASS_EN enables writeback-to-read forwarding inside id_regfile.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             ex_stall,
    input  logic             flush,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [7:0]       ex_ctrl,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_dst,
    output logic [31:0]      ex_instr,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic            valid;
        ctrl_t           ctrl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      dst;
        logic [31:0]     instr;
    } idex_t;

    idex_t            idex_q, idex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [5:0]      opcode;
    logic [4:0]      rs, rt, rd;
    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] rs_val, rt_val;
    logic            hazard;

    assign opcode   = id_instr[31:26];
    assign rs       = id_instr[25:21];
    assign rt       = id_instr[20:16];
    assign rd       = id_instr[15:11];
    assign dec_ctrl = decode_ctrl(opcode);
    assign imm_ext  = (opcode == OP_ORI) ? {{(XLEN-16){1'b0}}, id_instr[15:0]}
                                         : {{(XLEN-16){id_instr[15]}}, id_instr[15:0]};

    id_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (wb_we),
        .wa_i  (wb_rd),
        .wd_i  (wb_data),
        .ra0_i (rs),
        .ra1_i (rt),
        .rd0_o (rs_val),
        .rd1_o (rt_val)
    );

    // rt only counts as a source for R-type and store; I-type ALU ops write rt.
    assign hazard = idex_q.valid && idex_q.ctrl.mem_read && idex_q.dst != 5'd0 && id_valid &&
                    (idex_q.dst == rs ||
                     (idex_q.dst == rt && (opcode == OP_RTYPE || opcode == OP_SW)));
    assign id_stall = hazard || ex_stall;

    always_comb begin
        idex_d = idex_q;
        cnt_d  = cnt_q;
        if (flush) begin
            idex_d = '0;
        end else if (ex_stall) begin
            idex_d = idex_q;
        end else if (hazard) begin
            idex_d = '0;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else begin
            idex_d.valid = id_valid;
            idex_d.ctrl  = id_valid ? dec_ctrl : CTRL_NOP;
            idex_d.a     = rs_val;
            idex_d.b     = rt_val;
            idex_d.imm   = imm_ext;
            idex_d.rs    = rs;
            idex_d.rt    = rt;
            idex_d.dst   = dec_ctrl.reg_dst ? rd : rt;
            idex_d.instr = id_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
            cnt_q  <= '0;
        end else begin
            idex_q <= idex_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ex_valid   = idex_q.valid;
    assign ex_ctrl    = idex_q.ctrl;
    assign ex_a       = idex_q.a;
    assign ex_b       = idex_q.b;
    assign ex_imm     = idex_q.imm;
    assign ex_rs      = idex_q.rs;
    assign ex_rt      = idex_q.rt;
    assign ex_dst     = idex_q.dst;
    assign ex_instr   = idex_q.instr;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: reset, decode, load-use stalls, hold/flush and regfile write timing.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_stall;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        id_stall;
    logic        ex_valid;
    logic [7:0]  ex_ctrl;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic [31:0] ex_instr;
    logic [15:0] bubble_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NREG(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .ex_stall   (ex_stall),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .id_stall   (id_stall),
        .ex_valid   (ex_valid),
        .ex_ctrl    (ex_ctrl),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_imm     (ex_imm),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_dst     (ex_dst),
        .ex_instr   (ex_instr),
        .bubble_cnt (bubble_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction

    localparam logic [7:0] C_R    = 8'hC1;
    localparam logic [7:0] C_LW   = 8'h0D;
    localparam logic [7:0] C_SW   = 8'h0A;
    localparam logic [7:0] C_ADDI = 8'h09;
    localparam logic [7:0] C_ORI  = 8'h71;

    logic [31:0] i_addi_r4, i_lw, i_add_dep, i_sw_dep, i_addi_r8, i_ori, i_or7, i_r0r7, i_rd5;
    logic [31:0] exp_bypass;

    initial begin
        i_addi_r4 = enc_i(6'b001000, 5'd3, 5'd4, 16'hFFFF);
        i_lw      = enc_i(6'b100011, 5'd1, 5'd2, 16'h0000);
        i_add_dep = enc_r(5'd2, 5'd6, 5'd5, 6'h20);
        i_sw_dep  = enc_i(6'b101011, 5'd7, 5'd2, 16'h0000);
        i_addi_r8 = enc_i(6'b001000, 5'd9, 5'd8, 16'h0005);
        i_ori     = enc_i(6'b001101, 5'd0, 5'd10, 16'h8001);
        i_or7     = enc_r(5'd7, 5'd0, 5'd1, 6'h25);
        i_r0r7    = enc_r(5'd0, 5'd7, 5'd1, 6'h20);
        i_rd5     = enc_r(5'd5, 5'd0, 5'd1, 6'h20);
`ifdef WB_BYPASS_EN
        exp_bypass = 32'hAA;
`else
        exp_bypass = 32'h55;
`endif

        rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; ex_stall = 1'b0; flush = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        tick(); tick();
        chk("rst_valid", ex_valid, 0);
        chk("rst_ctrl", ex_ctrl, 0);
        chk("rst_cnt", bubble_cnt, 0);
        chk("rst_stall", id_stall, 0);
        rst_n = 1'b1;

        // Writeback r3, then addi r4,r3,-1 (also writes r5 for the later reset check)
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
        tick();
        wb_rd = 5'd5; wb_data = 32'h77;
        id_valid = 1'b1; id_instr = i_addi_r4;
        tick();
        wb_we = 1'b0;
        $display("txn addi r4,r3,-1: a=%0h imm=%0h dst=%0d ctrl=%0h", ex_a, ex_imm, ex_dst, ex_ctrl);
        chk("addi_valid", ex_valid, 1);
        chk("addi_a", ex_a, 32'h1234);
        chk("addi_imm", ex_imm, 32'hFFFFFFFF);
        chk("addi_dst", ex_dst, 4);
        chk("addi_ctrl", ex_ctrl, C_ADDI);
        chk("addi_rs", ex_rs, 3);

        // lw r2 followed by dependent add (rs use)
        id_instr = i_lw;
        tick();
        chk("lw_ctrl", ex_ctrl, C_LW);
        chk("lw_dst", ex_dst, 2);
        id_instr = i_add_dep;
        #1;
        chk("lu_rs_stall", id_stall, 1);
        tick();
        $display("txn load-use rs: valid=%0d cnt=%0d", ex_valid, bubble_cnt);
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_ctrl", ex_ctrl, 0);
        chk("lu_cnt1", bubble_cnt, 1);
        chk("lu_stall_clear", id_stall, 0);
        tick();
        chk("add_ctrl", ex_ctrl, C_R);
        chk("add_dst", ex_dst, 5);
        chk("add_rt", ex_rt, 6);

        // lw r2 then sw r2 (rt use) stalls; lw r2 then addi r8,r9 does not
        id_instr = i_lw;
        tick();
        id_instr = i_sw_dep;
        #1;
        chk("lu_rt_stall", id_stall, 1);
        tick();
        chk("lu_cnt2", bubble_cnt, 2);
        chk("sw_bubble_valid", ex_valid, 0);
        tick();
        $display("txn sw after lw: ctrl=%0h", ex_ctrl);
        chk("sw_ctrl", ex_ctrl, C_SW);
        id_instr = i_lw;
        tick();
        id_instr = i_addi_r8;
        #1;
        chk("nodep_stall", id_stall, 0);
        tick();
        chk("addi8_ctrl", ex_ctrl, C_ADDI);
        chk("addi8_dst", ex_dst, 8);
        chk("addi8_imm", ex_imm, 5);
        chk("nodep_cnt", bubble_cnt, 2);

        // ex_stall hold, then ori (zero-extend), then flush during stall
        ex_stall = 1'b1; id_instr = i_ori;
        #1;
        chk("exst_idstall", id_stall, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_instr", ex_instr, i_addi_r8);
            chk("hold_valid", ex_valid, 1);
        end
        ex_stall = 1'b0;
        tick();
        $display("txn ori: ctrl=%0h imm=%0h dst=%0d", ex_ctrl, ex_imm, ex_dst);
        chk("ori_ctrl", ex_ctrl, C_ORI);
        chk("ori_imm", ex_imm, 32'h00008001);
        chk("ori_dst", ex_dst, 10);
        ex_stall = 1'b1; flush = 1'b1;
        tick();
        chk("flush_valid", ex_valid, 0);
        chk("flush_instr", ex_instr, 0);
        flush = 1'b0; ex_stall = 1'b0;
        id_valid = 1'b0; id_instr = i_addi_r8;
        tick();
        chk("inval_valid", ex_valid, 0);
        chk("inval_ctrl", ex_ctrl, 0);

        // Same-cycle writeback vs read, and writes to r0
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
        tick();
        wb_data = 32'hAA; id_valid = 1'b1; id_instr = i_or7;
        tick();
        $display("txn or r1,r7,r0 with wb r7: a=%0h", ex_a);
        chk("wb_same_cycle", ex_a, exp_bypass);
        chk("or_b_r0", ex_b, 0);
        wb_rd = 5'd0; wb_data = 32'hFF; id_instr = i_r0r7;
        tick();
        chk("r0_bypass", ex_a, 0);
        chk("r7_new", ex_b, 32'hAA);
        wb_we = 1'b0;
        tick();
        chk("r0_after", ex_a, 0);

        // Reset mid-stall drops the held instruction and clears the regfile
        ex_stall = 1'b1;
        tick();
        chk("prereset_hold", ex_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ex_valid, 0);
        chk("mid_rst_instr", ex_instr, 0);
        chk("mid_rst_b", ex_b, 0);
        chk("mid_rst_cnt", bubble_cnt, 0);
        #1;
        rst_n = 1'b1; ex_stall = 1'b0; id_instr = i_rd5;
        tick();
        $display("txn read r5 after reset: a=%0h valid=%0d", ex_a, ex_valid);
        chk("r5_cleared", ex_a, 0);
        chk("post_rst_valid", ex_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
